// File: rtl/pe32_5.sv
// pe32_5: registered 32-to-5 priority encoder (highest set bit wins) with valid flag.
// Optional registered one-hot of the winning bit when PE32_5_ONEHOT_EN is defined.
module pe32_5 (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] Data,
    output logic [4:0]  Code,
    output logic        Valid
`ifdef PE32_5_ONEHOT_EN
    ,
    output logic [31:0] OneHot
`endif
);

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned CODE_W  = 5;
    localparam int unsigned GRP_W   = 8;
    localparam int unsigned N_GRP   = DATA_W / GRP_W;
    localparam int unsigned GCODE_W = 3;

    // Highest-set-bit index within one 8-bit group; 0 when the group is empty.
    function automatic logic [GCODE_W-1:0] enc8(input logic [GRP_W-1:0] v);
        logic [GCODE_W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(GRP_W); i++) begin
            if (v[i]) r = GCODE_W'(i);
        end
        return r;
    endfunction

    logic [N_GRP-1:0]   grp_any;
    logic [GCODE_W-1:0] grp_code [N_GRP];
    logic [CODE_W-1:0]  code_d, code_q;
    logic               valid_d, valid_q;

    // First level: per-group any/index.
    always_comb begin
        for (int g = 0; g < int'(N_GRP); g++) begin
            grp_any[g]  = |Data[g*GRP_W +: GRP_W];
            grp_code[g] = enc8(Data[g*GRP_W +: GRP_W]);
        end
    end

    // Second level: the highest non-empty group supplies the upper code bits.
    always_comb begin
        code_d  = '0;
        valid_d = |grp_any;
        if (grp_any[3])      code_d = {2'd3, grp_code[3]};
        else if (grp_any[2]) code_d = {2'd2, grp_code[2]};
        else if (grp_any[1]) code_d = {2'd1, grp_code[1]};
        else if (grp_any[0]) code_d = {2'd0, grp_code[0]};
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            code_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            code_q  <= code_d;
            valid_q <= valid_d;
        end
    end

    assign Code  = code_q;
    assign Valid = valid_q;

`ifdef PE32_5_ONEHOT_EN
    logic [DATA_W-1:0] onehot_d, onehot_q;

    always_comb begin
        onehot_d = '0;
        if (valid_d) onehot_d = DATA_W'(1) << code_d;
    end

    always_ff @(posedge clock) begin
        if (!clear) onehot_q <= '0;
        else        onehot_q <= onehot_d;
    end

    assign OneHot = onehot_q;
`endif

endmodule

// File: tb/tb_pe32_5.sv
// Scoreboard bench for pe32_5: expected results queued at drive, popped one edge later.
module tb_pe32_5;

    typedef struct packed {
        logic [4:0]  code;
        logic        valid;
        logic [31:0] onehot;
    } exp_t;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] Data  = '0;
    logic [4:0]  Code;
    logic        Valid;
`ifdef PE32_5_ONEHOT_EN
    logic [31:0] OneHot;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    exp_t sb_q[$];

    pe32_5 dut (
        .clock (clock),
        .clear (clear),
        .Data  (Data),
        .Code  (Code),
        .Valid (Valid)
`ifdef PE32_5_ONEHOT_EN
        ,
        .OneHot(OneHot)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference: scan upward, last set bit seen is the winner.
    function automatic exp_t model(input logic [31:0] d, input logic clr);
        exp_t e;
        e = '0;
        if (clr) begin
            for (int i = 0; i < 32; i++) begin
                if (d[i]) begin
                    e.code  = 5'(i);
                    e.valid = 1'b1;
                end
            end
        end
        if (e.valid) e.onehot = 32'h1 << e.code;
        return e;
    endfunction

    task automatic step(input string tag, input logic [31:0] d, input logic clr);
        exp_t e;
        @(negedge clock);
        Data  = d;
        clear = clr;
        sb_q.push_back(model(d, clr));
        @(posedge clock);
        #1;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_code"},  32'(Code),  32'(e.code));
            check({tag, "_valid"}, 32'(Valid), 32'(e.valid));
`ifdef PE32_5_ONEHOT_EN
            check({tag, "_onehot"}, OneHot, e.onehot);
`endif
        end
    endtask

    logic [31:0] sweep [10] = '{32'h00000001, 32'h00000002, 32'h00000004, 32'h00000008,
                                32'h00000010, 32'h00000100, 32'h00010000, 32'h00100000,
                                32'h01000000, 32'h80000000};
    logic [4:0]  sweep_code [10] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd8, 5'd16, 5'd20, 5'd24, 5'd31};
    logic [31:0] multi [5] = '{32'h00000003, 32'h0000000F, 32'h00000105, 32'h00400021, 32'hC0000001};
    logic [4:0]  multi_code [5] = '{5'd1, 5'd3, 5'd8, 5'd22, 5'd31};

    initial begin
        // Reset held across two edges with all-ones data.
        step("rst0", 32'hFFFFFFFF, 1'b0);
        step("rst1", 32'hFFFFFFFF, 1'b0);

        for (int i = 0; i < 10; i++) begin
            step("sweep", sweep[i], 1'b1);
            check("sweep_tbl", 32'(Code), 32'(sweep_code[i]));
        end
        for (int i = 0; i < 5; i++) begin
            step("multi", multi[i], 1'b1);
            check("multi_tbl", 32'(Code), 32'(multi_code[i]));
        end

        step("zero", 32'h0, 1'b1);
        check("zero_code_lit", 32'(Code), 32'd0);
        check("zero_valid_lit", 32'(Valid), 32'd0);
        step("ones", 32'hFFFFFFFF, 1'b1);
        check("ones_code_lit", 32'(Code), 32'd31);
`ifdef PE32_5_ONEHOT_EN
        step("oh22", 32'h00400021, 1'b1);
        check("oh22_lit", OneHot, 32'h00400000);
        step("oh0", 32'h0, 1'b1);
        check("oh0_lit", OneHot, 32'h0);
`endif

        // Back-to-back random stream with a mid-stream reset.
        for (int i = 0; i < 24; i++) begin
            logic [31:0] d;
            d = $urandom();
            if (i % 5 == 1) d = d >> $urandom_range(0, 31);
            if (i % 7 == 3) d = 32'h0;
            step("stream", d, (i == 12) ? 1'b0 : 1'b1);
        end

        // Data toggling between edges must not matter; only the edge value counts.
        @(negedge clock);
        Data = 32'h00000001;
        #2;
        Data = 32'h00008000;
        sb_q.push_back(model(32'h00008000, 1'b1));
        @(posedge clock);
        #1;
        if (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check("toggle_code", 32'(Code), 32'(e.code));
        end

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
